hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Produces the stall and flush controls consumed by the fetch-to-decode register and the PC, and the bubble (flush) control for the decode-to-execute register.
- Produces the execute-stage and decode-stage (branch compare) forwarding selects.
- Tracks a multicycle multiply/divide unit with an internal busy FSM, so that HI/LO readers and back-to-back mult/div instructions stall until the result is written.

Parameters:
- MD_LATENCY, 4, cycles the mult/div unit stays busy after issue (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- rs_D  input  5  decode-stage source register rs.
- rt_D  input  5  decode-stage source register rt.
- rs_E  input  5  execute-stage rs.
- rt_E  input  5  execute-stage rt.
- write_reg_E  input  5  execute-stage destination register.
- write_reg_M  input  5  memory-stage destination register.
- write_reg_W  input  5  writeback-stage destination register.
- reg_write_E  input  1  destination write enable, execute stage.
- reg_write_M  input  1  destination write enable, memory stage.
- reg_write_W  input  1  destination write enable, writeback stage.
- mem_to_reg_E  input  1  load instruction in execute.
- mem_to_reg_M  input  1  load instruction in memory.
- branch_D  input  1  branch instruction in decode.
- pc_src_D  input  1  branch taken or jump resolved in decode.
- md_start_D  input  1  mult/div instruction in decode.
- md_start_E  input  1  mult/div instruction in execute (issue).
- hilo_read_D  input  1  mfhi/mflo in decode.
- stall_pc  output  1  hold PC.
- stall_f2d  output  1  hold fetch-to-decode register.
- flush_f2d  output  1  clear fetch-to-decode register.
- flush_d2e  output  1  clear decode-to-execute register (bubble).
- forward_a_D  output  1  forward ALU result from memory stage to branch comparator operand A.
- forward_b_D  output  1  forward ALU result from memory stage to branch comparator operand B.
- forward_a_E  output  2  execute operand A select: 00 register file, 10 memory stage, 01 writeback stage.
- forward_b_E  output  2  execute operand B select, same encoding as forward_a_E.
- md_busy  output  1  mult/div unit busy.
- hilo_we  output  1  one-cycle HI/LO write strobe.

Behaviour:
- Register 0 never matches in any hazard or forward comparison.
- All outputs except the FSM state are combinational, valid in the same cycle.
- While rst is low, every output is 0 regardless of the inputs.

Execute-stage forwarding:
- forward_a_E = 10 if reg_write_M && write_reg_M == rs_E.
- Otherwise 01 if reg_write_W && write_reg_W == rs_E.
- Otherwise 00.
- The memory stage has priority over writeback. forward_b_E follows the same rules using rt_E.

Decode-stage forwarding:
- forward_a_D = reg_write_M && write_reg_M == rs_D.
- forward_b_D = reg_write_M && write_reg_M == rt_D.

Stall sources (stall_any is the OR of these):
- lw_stall = mem_to_reg_E && write_reg_E ∈ {rs_D, rt_D}.
- br_stall = branch_D && ((reg_write_E && write_reg_E ∈ {rs_D, rt_D}) || (mem_to_reg_M && write_reg_M ∈ {rs_D, rt_D})).
- md_stall = md_busy && (hilo_read_D || md_start_D).

Stall and flush outputs:
- stall_pc = stall_f2d = flush_d2e = stall_any.
- flush_f2d = pc_src_D && !stall_any. Stall wins, because the branch operands are not yet valid.

Mult/div FSM (states IDLE, BUSY; 4-bit down-counter cnt):
- Reset: state IDLE, cnt 0.
- IDLE, md_start_E = 1: go to BUSY, cnt = MD_LATENCY-1.
- BUSY, cnt != 0: cnt decrements.
- BUSY, cnt == 0: hilo_we = 1 for this cycle; next state IDLE.
- md_busy = (state == BUSY). It is high for exactly MD_LATENCY cycles, starting the cycle after issue.
- md_start_E while BUSY is ignored. It cannot occur legally because md_stall blocks it.
- An issue in the same cycle as the IDLE return is impossible, since md_busy is still 1 in that cycle.
- rst falling mid-operation forces IDLE and cnt 0 immediately. No hilo_we is issued.

Test Plan:
- Load-use: mem_to_reg_E=1, write_reg_E=8, rs_D=8 -> stall_pc=stall_f2d=flush_d2e=1, flush_f2d=0. Set write_reg_E=0 instead -> all 0.
- Forward priority: reg_write_M=1, write_reg_M=9, reg_write_W=1, write_reg_W=9, rs_E=9 -> forward_a_E=10. Set reg_write_M=0 -> forward_a_E=01.
- Branch hazard:
  - branch_D=1, pc_src_D=1, reg_write_E=1, write_reg_E=rt_D=5 -> stall_f2d=1, flush_f2d=0.
  - Next cycle, hazard cleared and write_reg_M=5 with reg_write_M=1 -> forward_b_D=1, flush_f2d=1, stall_f2d=0.
- Mult/div with MD_LATENCY=4:
  - Pulse md_start_E at cycle 0 -> md_busy=1 for cycles 1-4, hilo_we=1 only in cycle 4.
  - hilo_read_D=1 throughout -> stall_f2d=1 in cycles 1-4, 0 in cycle 5.
- Reset mid-busy: issue mult, drop rst at cycle 2 -> md_busy=0 and all outputs 0 immediately. Release rst -> IDLE, no hilo_we pulse.
- Jump without hazard: pc_src_D=1, branch_D=0, no matches -> flush_f2d=1, stall_pc=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: stall/flush generation,
// execute/decode forwarding selects, and multicycle mult/div busy tracking.

module hc_fwd_sel (
  input  logic [4:0] src_E,
  input  logic [4:0] src_D,
  input  logic [4:0] write_reg_M,
  input  logic [4:0] write_reg_W,
  input  logic       reg_write_M,
  input  logic       reg_write_W,
  output logic [1:0] fwd_E,
  output logic       fwd_D
);
  logic w_m_hit_E, w_w_hit_E;

  // $zero is hardwired, so a write to it is never a real producer
  assign w_m_hit_E = reg_write_M && (src_E != 5'd0) && (write_reg_M == src_E);
  assign w_w_hit_E = reg_write_W && (src_E != 5'd0) && (write_reg_W == src_E);

  always_comb begin
    fwd_E = 2'b00;
    if (w_m_hit_E)      fwd_E = 2'b10;
    else if (w_w_hit_E) fwd_E = 2'b01;
  end

  assign fwd_D = reg_write_M && (src_D != 5'd0) && (write_reg_M == src_D);
endmodule

module hazard_ctrl #(
  parameter int MD_LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [4:0] rs_E,
  input  logic [4:0] rt_E,
  input  logic [4:0] write_reg_E,
  input  logic [4:0] write_reg_M,
  input  logic [4:0] write_reg_W,
  input  logic       reg_write_E,
  input  logic       reg_write_M,
  input  logic       reg_write_W,
  input  logic       mem_to_reg_E,
  input  logic       mem_to_reg_M,
  input  logic       branch_D,
  input  logic       pc_src_D,
  input  logic       md_start_D,
  input  logic       md_start_E,
  input  logic       hilo_read_D,
  output logic       stall_pc,
  output logic       stall_f2d,
  output logic       flush_f2d,
  output logic       flush_d2e,
  output logic       forward_a_D,
  output logic       forward_b_D,
  output logic [1:0] forward_a_E,
  output logic [1:0] forward_b_E,
  output logic       md_busy,
  output logic       hilo_we
);
  typedef enum logic {S_IDLE, S_BUSY} md_state_t;

  localparam logic [3:0] CNT_INIT = 4'(MD_LATENCY - 1);

  md_state_t        r_state, w_state_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic             w_hilo_we;

  logic [1:0][4:0]  w_src_E, w_src_D;
  logic [1:0][1:0]  w_fwd_E;
  logic [1:0]       w_fwd_D;

  logic             w_hit_E, w_hit_M;
  logic             w_lw_stall, w_br_stall, w_md_stall, w_stall;
  logic             w_busy;

  // index 0 = operand A (rs), index 1 = operand B (rt)
  assign w_src_E = {rt_E, rs_E};
  assign w_src_D = {rt_D, rs_D};

  for (genvar g = 0; g < 2; g++) begin : g_op
    hc_fwd_sel u_sel (
      .src_E       (w_src_E[g]),
      .src_D       (w_src_D[g]),
      .write_reg_M (write_reg_M),
      .write_reg_W (write_reg_W),
      .reg_write_M (reg_write_M),
      .reg_write_W (reg_write_W),
      .fwd_E       (w_fwd_E[g]),
      .fwd_D       (w_fwd_D[g])
    );
  end

  assign w_hit_E = (write_reg_E != 5'd0) && ((write_reg_E == rs_D) || (write_reg_E == rt_D));
  assign w_hit_M = (write_reg_M != 5'd0) && ((write_reg_M == rs_D) || (write_reg_M == rt_D));

  assign w_busy     = (r_state == S_BUSY);
  assign w_lw_stall = mem_to_reg_E && w_hit_E;
  assign w_br_stall = branch_D && ((reg_write_E && w_hit_E) || (mem_to_reg_M && w_hit_M));
  assign w_md_stall = w_busy && (hilo_read_D || md_start_D);
  assign w_stall    = w_lw_stall || w_br_stall || w_md_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // An issue while BUSY cannot be legal (md_stall holds it in decode), so it is dropped
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hilo_we   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (md_start_E) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      S_BUSY: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_hilo_we   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are forced low throughout reset, independent of inputs
  assign stall_pc    = rst && w_stall;
  assign stall_f2d   = rst && w_stall;
  assign flush_d2e   = rst && w_stall;
  assign flush_f2d   = rst && pc_src_D && !w_stall;
  assign forward_a_D = rst && w_fwd_D[0];
  assign forward_b_D = rst && w_fwd_D[1];
  assign forward_a_E = rst ? w_fwd_E[0] : 2'b00;
  assign forward_b_E = rst ? w_fwd_E[1] : 2'b00;
  assign md_busy     = rst && w_busy;
  assign hilo_we     = rst && w_hilo_we;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_hazard_ctrl;
  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_D, rt_D, rs_E, rt_E, write_reg_E, write_reg_M, write_reg_W;
  logic       reg_write_E, reg_write_M, reg_write_W, mem_to_reg_E, mem_to_reg_M;
  logic       branch_D, pc_src_D, md_start_D, md_start_E, hilo_read_D;
  logic       stall_pc, stall_f2d, flush_f2d, flush_d2e, forward_a_D, forward_b_D;
  logic [1:0] forward_a_E, forward_b_E;
  logic       md_busy, hilo_we;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;
  int busy_left;

  hazard_ctrl #(.MD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E),
    .write_reg_E(write_reg_E), .write_reg_M(write_reg_M), .write_reg_W(write_reg_W),
    .reg_write_E(reg_write_E), .reg_write_M(reg_write_M), .reg_write_W(reg_write_W),
    .mem_to_reg_E(mem_to_reg_E), .mem_to_reg_M(mem_to_reg_M),
    .branch_D(branch_D), .pc_src_D(pc_src_D), .md_start_D(md_start_D),
    .md_start_E(md_start_E), .hilo_read_D(hilo_read_D),
    .stall_pc(stall_pc), .stall_f2d(stall_f2d), .flush_f2d(flush_f2d), .flush_d2e(flush_d2e),
    .forward_a_D(forward_a_D), .forward_b_D(forward_b_D),
    .forward_a_E(forward_a_E), .forward_b_E(forward_b_E),
    .md_busy(md_busy), .hilo_we(hilo_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: remaining busy cycles of the mult/div unit after an issue
  always @(posedge clk or negedge rst) begin
    if (!rst)               busy_left <= 0;
    else if (busy_left > 0) busy_left <= busy_left - 1;
    else if (md_start_E)    busy_left <= LAT;
  end

  function automatic bit hit2(input logic [4:0] w, input logic [4:0] a, input logic [4:0] b);
    return (w != 0) && (w == a || w == b);
  endfunction

  function automatic logic [1:0] fe(input logic [4:0] s);
    if (reg_write_M && s != 0 && write_reg_M == s) return 2'b10;
    if (reg_write_W && s != 0 && write_reg_W == s) return 2'b01;
    return 2'b00;
  endfunction

  // Packed: {stall_pc,stall_f2d,flush_f2d,flush_d2e,fwdaD,fwdbD,fwdaE,fwdbE,busy,hilo_we}
  function automatic logic [11:0] model_out();
    bit busy, st;
    if (!rst) return 12'h0;
    busy = busy_left > 0;
    st = (mem_to_reg_E && hit2(write_reg_E, rs_D, rt_D))
      || (branch_D && ((reg_write_E && hit2(write_reg_E, rs_D, rt_D))
                    || (mem_to_reg_M && hit2(write_reg_M, rs_D, rt_D))))
      || (busy && (hilo_read_D || md_start_D));
    return {st, st, pc_src_D && !st, st,
            reg_write_M && rs_D != 0 && write_reg_M == rs_D,
            reg_write_M && rt_D != 0 && write_reg_M == rt_D,
            fe(rs_E), fe(rt_E), busy, busy_left == 1};
  endfunction

  function automatic logic [11:0] dut_out();
    return {stall_pc, stall_f2d, flush_f2d, flush_d2e, forward_a_D, forward_b_D,
            forward_a_E, forward_b_E, md_busy, hilo_we};
  endfunction

  always @(negedge clk) if (cmp_en) chk("model_outs", 32'(dut_out()), 32'(model_out()));

  task automatic clr();
    {rs_D, rt_D, rs_E, rt_E, write_reg_E, write_reg_M, write_reg_W} = '0;
    {reg_write_E, reg_write_M, reg_write_W, mem_to_reg_E, mem_to_reg_M} = '0;
    {branch_D, pc_src_D, md_start_D, md_start_E, hilo_read_D} = '0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    clr();
    // Reset holds every output low even with hazards presented
    mem_to_reg_E = 1; write_reg_E = 8; rs_D = 8; pc_src_D = 1;
    reg_write_M = 1; write_reg_M = 3; rs_E = 3;
    cmp_en = 1'b1;
    look();
    chk("reset_outs", 32'(dut_out()), 32'h0);
    next(); rst = 1'b1; clr();

    // Load-use
    mem_to_reg_E = 1; write_reg_E = 8; rs_D = 8;
    look();
    chk("lu_stall", 32'({stall_pc, stall_f2d, flush_d2e, flush_f2d}), 32'b1110);
    next(); write_reg_E = 0;
    look();
    chk("lu_r0", 32'({stall_pc, stall_f2d, flush_d2e, flush_f2d}), 32'b0000);

    // Forward priority
    next(); clr();
    reg_write_M = 1; write_reg_M = 9; reg_write_W = 1; write_reg_W = 9; rs_E = 9;
    look(); chk("fwd_mem", 32'(forward_a_E), 32'b10);
    next(); reg_write_M = 0;
    look(); chk("fwd_wb", 32'(forward_a_E), 32'b01);

    // Branch hazard, then resolve with decode forwarding
    next(); clr();
    branch_D = 1; pc_src_D = 1; reg_write_E = 1; write_reg_E = 5; rt_D = 5;
    look(); chk("br_stall", 32'({stall_f2d, flush_f2d}), 32'b10);
    next(); reg_write_E = 0; write_reg_E = 0; reg_write_M = 1; write_reg_M = 5;
    look(); chk("br_fwd", 32'({forward_b_D, flush_f2d, stall_f2d}), 32'b110);

    // Jump without hazard
    next(); clr(); pc_src_D = 1; rs_D = 4; rt_D = 7;
    look(); chk("jump", 32'({flush_f2d, stall_pc}), 32'b10);

    // Mult/div busy window with a HI/LO reader waiting in decode
    next(); clr(); md_start_E = 1; hilo_read_D = 1;
    look(); chk("md_c0", 32'({md_busy, hilo_we, stall_f2d}), 32'b000);
    for (int c = 1; c <= 5; c++) begin
      next(); md_start_E = 0;
      look();
      chk($sformatf("md_c%0d", c), 32'({md_busy, hilo_we, stall_f2d}),
          32'({c <= 4, c == 4, c <= 4}));
    end

    // Reset mid-busy
    next(); clr(); md_start_E = 1; hilo_read_D = 1;
    next(); md_start_E = 0;
    next(); rst = 1'b0;
    #1; chk("rst_mid_busy", 32'(dut_out()), 32'h0);
    next(); rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      look(); chk("rst_no_hilo", 32'({md_busy, hilo_we}), 32'b00);
      next();
    end

    // Randomized traffic; small register range to provoke many matches
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) != 0);
      rs_D = 5'($urandom_range(0, 3)); rt_D = 5'($urandom_range(0, 3));
      rs_E = 5'($urandom_range(0, 3)); rt_E = 5'($urandom_range(0, 3));
      write_reg_E = 5'($urandom_range(0, 3));
      write_reg_M = 5'($urandom_range(0, 3));
      write_reg_W = 5'($urandom_range(0, 3));
      {reg_write_E, reg_write_M, reg_write_W, mem_to_reg_E, mem_to_reg_M} = 5'($urandom);
      {branch_D, pc_src_D, md_start_D, hilo_read_D} = 4'($urandom);
      md_start_E = ($urandom_range(0, 3) == 0);
      next();
    end

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
